// File: rtl/iterative_multiplier_pkg.sv
// rtl/iterative_multiplier_pkg.sv - shared types and constants for the iterative multiplier
//
// Purpose : FSM state encoding, register-file constants, opcode encoding and
//           a constant-evaluable ceil(log2) used to size the step counter.
// Ports   : none (package).
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // XZR: writes to this index are discarded by the register file.
   localparam logic [4:0] ZERO_REG = 5'd31;

   localparam logic OP_MUL   = 1'b0;
   localparam logic OP_UMULH = 1'b1;

   // Smallest r with 2**r >= value; returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/iterative_multiplier_if.sv
// rtl/iterative_multiplier_if.sv - start/ready request and register-file write bundle
//
// Purpose : groups the operand request (Start/Op/BusA/BusB/Rd), the handshake
//           status (Ready/Busy) and the register-file write port (BusW/RW/RegWr).
// Modports:
//   master - issuing side (decode stage / testbench): drives the request.
//   slave  - the multiplier: consumes the request, drives status and write port.
interface iterative_multiplier_if #(
   parameter int WIDTH = 64
);
   logic             Start;
   logic             Ready;
   logic             Busy;
   logic             Op;
   logic [WIDTH-1:0] BusA;
   logic [WIDTH-1:0] BusB;
   logic [4:0]       Rd;
   logic [WIDTH-1:0] BusW;
   logic [4:0]       RW;
   logic             RegWr;

   modport master (
      output Start, Op, BusA, BusB, Rd,
      input  Ready, Busy, BusW, RW, RegWr
   );

   modport slave (
      input  Start, Op, BusA, BusB, Rd,
      output Ready, Busy, BusW, RW, RegWr
   );
endinterface

// File: rtl/iterative_multiplier_step.sv
// rtl/iterative_multiplier_step.sv - one shift-add step of the multiplier datapath
//
// Purpose : retires a single multiplier bit: conditionally adds the aligned
//           multiplicand into the accumulator and advances the multiplicand
//           one bit position for the next step in the chain.
// Ports   :
//   acc_i   in  W  running accumulator
//   mcand_i in  W  multiplicand already shifted to this bit's position
//   bit_i   in  1  multiplier bit being retired
//   acc_o   out W  acc_i + (bit_i ? mcand_i : 0), modulo 2**W
//   mcand_o out W  mcand_i << 1
module mul_step #(
   parameter int W = 128
) (
   input  logic [W-1:0] acc_i,
   input  logic [W-1:0] mcand_i,
   input  logic         bit_i,
   output logic [W-1:0] acc_o,
   output logic [W-1:0] mcand_o
);

   assign acc_o   = bit_i ? (acc_i + mcand_i) : acc_i;
   assign mcand_o = mcand_i << 1;

endmodule

// File: rtl/iterative_multiplier.sv
// rtl/iterative_multiplier.sv - multi-cycle unsigned shift-add multiplier for MUL/UMULH
//
// Purpose : accepts one request while Ready, spends WIDTH/BITS_PER_CYCLE cycles
//           in BUSY retiring multiplier bits, then spends one DONE cycle
//           presenting the product on the register-file write port.
// Parameters:
//   WIDTH          operand width
//   BITS_PER_CYCLE multiplier bits retired per clock (1, 2 or 4)
// Ports   :
//   Clk    in  clock, all state on posedge
//   Rst_n  in  synchronous active-low reset
//   bus    slave modport of iterative_multiplier_if
//          Start/Op/BusA/BusB/Rd sampled on the accepting edge;
//          Ready (IDLE), Busy (BUSY or DONE), BusW/RW registered result,
//          RegWr high for the DONE cycle unless RW is XZR.
// Build option:
//   UMULH_EN  defined   -> 2*WIDTH accumulator, Op selects low/high half
//             undefined -> WIDTH accumulator, Op ignored, BusW is the low half
module iterative_multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH          = 64,
   parameter int BITS_PER_CYCLE = 1
) (
   input logic                 Clk,
   input logic                 Rst_n,
   iterative_multiplier_if.slave bus
);

   localparam int N     = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = (clog2(N) < 1) ? 1 : clog2(N);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   // Without UMULH only the low half is ever observed, and the low half of a
   // product depends only on the low halves of the partial products, so the
   // accumulator and shifted multiplicand can be truncated to WIDTH bits.
`ifdef UMULH_EN
   localparam int ACC_W = 2 * WIDTH;
`else
   localparam int ACC_W = WIDTH;
`endif

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [ACC_W-1:0]   acc_q,   acc_d;
   logic [ACC_W-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   b_q,     b_d;
   logic [4:0]         rd_q,    rd_d;
   logic [WIDTH-1:0]   busw_q,  busw_d;
   logic [4:0]         rw_q,    rw_d;
`ifdef UMULH_EN
   logic               op_q,    op_d;
`endif

   // Step chain: element j feeds step j; element BITS_PER_CYCLE is the
   // accumulator/multiplicand after this cycle's bits have been retired.
   logic [BITS_PER_CYCLE:0][ACC_W-1:0] acc_chain;
   logic [BITS_PER_CYCLE:0][ACC_W-1:0] mc_chain;
   logic [WIDTH-1:0]                   result;

   assign acc_chain[0] = acc_q;
   assign mc_chain[0]  = mcand_q;

   for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_step
      mul_step #(
         .W (ACC_W)
      ) u_step (
         .acc_i   (acc_chain[j]),
         .mcand_i (mc_chain[j]),
         .bit_i   (b_q[j]),
         .acc_o   (acc_chain[j+1]),
         .mcand_o (mc_chain[j+1])
      );
   end

   // Result taken from the post-step accumulator so BusW is registered on the
   // same edge that performs the final step.
`ifdef UMULH_EN
   assign result = (op_q == OP_UMULH) ? acc_chain[BITS_PER_CYCLE][ACC_W-1:WIDTH]
                                      : acc_chain[BITS_PER_CYCLE][WIDTH-1:0];
`else
   assign result = acc_chain[BITS_PER_CYCLE];
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      b_d     = b_q;
      rd_d    = rd_q;
      busw_d  = busw_q;
      rw_d    = rw_q;
`ifdef UMULH_EN
      op_d    = op_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               state_d = BUSY;
               cnt_d   = '0;
               acc_d   = '0;
               mcand_d = ACC_W'(bus.BusA);
               b_d     = bus.BusB;
               rd_d    = bus.Rd;
`ifdef UMULH_EN
               op_d    = bus.Op;
`endif
            end
         end
         BUSY: begin
            acc_d   = acc_chain[BITS_PER_CYCLE];
            mcand_d = mc_chain[BITS_PER_CYCLE];
            b_d     = b_q >> BITS_PER_CYCLE;
            cnt_d   = cnt_q + 1'b1;
            // The edge seeing count N-1 performs step N and closes the op.
            if (cnt_q == LAST) begin
               state_d = DONE;
               busw_d  = result;
               rw_d    = rd_q;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         b_q     <= '0;
         rd_q    <= '0;
         busw_q  <= '0;
         rw_q    <= '0;
`ifdef UMULH_EN
         op_q    <= OP_MUL;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         b_q     <= b_d;
         rd_q    <= rd_d;
         busw_q  <= busw_d;
         rw_q    <= rw_d;
`ifdef UMULH_EN
         op_q    <= op_d;
`endif
      end
   end

   assign bus.Ready = (state_q == IDLE);
   assign bus.Busy  = (state_q != IDLE);
   assign bus.RegWr = (state_q == DONE) && (rw_q != ZERO_REG);
   assign bus.BusW  = busw_q;
   assign bus.RW    = rw_q;

endmodule

// File: tb/tb_iterative_multiplier.sv
// tb/tb_iterative_multiplier.sv - self-checking bench for iterative_multiplier
module tb_iterative_multiplier;

   localparam int W  = 64;
   localparam int N1 = 64;
   localparam int N4 = 16;

`ifdef UMULH_EN
   localparam bit HAS_UMULH = 1'b1;
`else
   localparam bit HAS_UMULH = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] w;
      logic [4:0]   rw;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   exp_t sb[$];

   iterative_multiplier_if #(.WIDTH(W)) bus ();
   iterative_multiplier_if #(.WIDTH(W)) bus4 ();

   iterative_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (bus)
   );

   iterative_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic op);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return (HAS_UMULH && op) ? p[2*W-1:W] : p[W-1:0];
   endfunction

   // Scoreboard: every write strobe must match the oldest outstanding request.
   always @(negedge clk) begin
      if (bus.RegWr === 1'b1) begin
         if (sb.size() == 0) begin
            check("regwr_unexpected", 128'(bus.RegWr), 128'(0));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("busw", 128'(bus.BusW), 128'(e.w));
            check("rw", 128'(bus.RW), 128'(e.rw));
         end
      end
   end

   // Issue one op on the BITS_PER_CYCLE=1 instance and follow it through
   // cycles t0..t0+N+1. glitch_k >= 1 pulses a second Start in cycle t0+glitch_k.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] rd, input logic op, input int glitch_k);
      logic [W-1:0] w;
      int regwr_at, regwr_n, busy_n;
      w = model(a, b, op);
      @(negedge clk);
      check("ready_before", 128'(bus.Ready), 128'(1));
      bus.Start = 1'b1;
      bus.BusA  = a;
      bus.BusB  = b;
      bus.Rd    = rd;
      bus.Op    = op;
      if (rd != 5'd31) sb.push_back('{w: w, rw: rd});
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      bus.BusA  = {$urandom, $urandom};
      bus.BusB  = {$urandom, $urandom};
      bus.Rd    = 5'($urandom_range(0, 31));
      bus.Op    = 1'($urandom_range(0, 1));
      regwr_at = -1;
      regwr_n  = 0;
      busy_n   = 0;
      for (int k = 0; k <= N1 + 1; k++) begin
         if (k > 0) @(posedge clk);
         @(negedge clk);
         if (bus.RegWr === 1'b1) begin
            regwr_at = k;
            regwr_n++;
         end
         if (bus.Busy === 1'b1) busy_n++;
         if (k == glitch_k) begin
            bus.Start = 1'b1;
            bus.BusA  = 64'd100;
         end else begin
            bus.Start = 1'b0;
         end
      end
      check("regwr_cycle", 128'(regwr_at), (rd == 5'd31) ? 128'(-1) : 128'(N1));
      check("regwr_count", 128'(regwr_n), (rd == 5'd31) ? 128'(0) : 128'(1));
      check("busy_cycles", 128'(busy_n), 128'(N1 + 1));
      check("ready_after", 128'(bus.Ready), 128'(1));
      check("busw_hold", 128'(bus.BusW), 128'(w));
      check("rw_hold", 128'(bus.RW), 128'(rd));
   endtask

   // Same for the BITS_PER_CYCLE=4 instance (MUL only).
   task automatic run_op4(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] rd);
      logic [W-1:0] w, seen;
      int regwr_at, busy_n;
      w = model(a, b, 1'b0);
      @(negedge clk);
      bus4.Start = 1'b1;
      bus4.BusA  = a;
      bus4.BusB  = b;
      bus4.Rd    = rd;
      bus4.Op    = 1'b0;
      @(posedge clk);
      #1;
      bus4.Start = 1'b0;
      bus4.BusA  = {$urandom, $urandom};
      bus4.BusB  = {$urandom, $urandom};
      regwr_at = -1;
      busy_n   = 0;
      seen     = '0;
      for (int k = 0; k <= N4 + 1; k++) begin
         if (k > 0) @(posedge clk);
         @(negedge clk);
         if (bus4.RegWr === 1'b1) begin
            regwr_at = k;
            seen     = bus4.BusW;
         end
         if (bus4.Busy === 1'b1) busy_n++;
      end
      check("bpc4_regwr_cycle", 128'(regwr_at), 128'(N4));
      check("bpc4_busw", 128'(seen), 128'(w));
      check("bpc4_busy_cycles", 128'(busy_n), 128'(N4 + 1));
      check("bpc4_ready_after", 128'(bus4.Ready), 128'(1));
   endtask

   initial begin
      int regwr_n, busy_n;
      checks     = 0;
      errors     = 0;
      rst_n      = 1'b0;
      bus.Start  = 1'b0;
      bus.Op     = 1'b0;
      bus.BusA   = '0;
      bus.BusB   = '0;
      bus.Rd     = '0;
      bus4.Start = 1'b0;
      bus4.Op    = 1'b0;
      bus4.BusA  = '0;
      bus4.BusB  = '0;
      bus4.Rd    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 128'(bus.Ready), 128'(1));
      check("rst_busy", 128'(bus.Busy), 128'(0));
      check("rst_regwr", 128'(bus.RegWr), 128'(0));
      check("rst_busw", 128'(bus.BusW), 128'(0));
      check("rst_rw", 128'(bus.RW), 128'(0));
      check("rst4_ready", 128'(bus4.Ready), 128'(1));
      rst_n = 1'b1;

      // Basic product and latency.
      run_op(64'd3, 64'd5, 5'd2, 1'b0, -1);
      // All-ones operands: low half is 1, high half is 2^64-2.
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 1'b0, -1);
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 1'b1, -1);
      // XZR destination: full duration, no strobe.
      run_op(64'd7, 64'd9, 5'd31, 1'b0, -1);
      // Start during BUSY must be ignored.
      run_op(64'd2, 64'd3, 5'd4, 1'b0, 10);
      // Zero operands still take the full N cycles.
      run_op(64'd0, {$urandom, $urandom}, 5'd5, 1'b0, -1);
      run_op({$urandom, $urandom}, 64'd0, 5'd6, 1'b1, -1);
      // Random operands.
      for (int i = 0; i < 4; i++) begin
         run_op({$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 30)),
                1'($urandom_range(0, 1)), -1);
      end

      // Reset in the middle of an op aborts it with no write.
      @(negedge clk);
      bus.Start = 1'b1;
      bus.BusA  = 64'd2;
      bus.BusB  = 64'd3;
      bus.Rd    = 5'd4;
      bus.Op    = 1'b0;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_ready", 128'(bus.Ready), 128'(1));
      check("midrst_busy", 128'(bus.Busy), 128'(0));
      check("midrst_busw", 128'(bus.BusW), 128'(0));
      check("midrst_rw", 128'(bus.RW), 128'(0));
      rst_n   = 1'b1;
      regwr_n = 0;
      busy_n  = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.RegWr === 1'b1) regwr_n++;
         if (bus.Busy === 1'b1) busy_n++;
      end
      check("midrst_no_regwr", 128'(regwr_n), 128'(0));
      check("midrst_no_busy", 128'(busy_n), 128'(0));

      // Four bits per cycle.
      run_op4(64'h1_0000_0000, 64'h10, 5'd9);
      run_op4({$urandom, $urandom}, {$urandom, $urandom}, 5'd10);
      run_op4(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11);

      check("sb_drained", 128'(sb.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
